dig_win_cnt: RTL and testbench

DIG_WIN_CNT -- requirements
Module: dig_win_cnt

---
 rtl/dig_pkg.sv | 18 +
 rtl/dig_ch_cnt.sv | 71 +++++++
 rtl/dig_win_cnt.sv | 87 ++++++++
 tb/tb_dig_win_cnt.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dig_pkg.sv
`default_nettype none
// ============================================================================
//  dig_pkg
//  Shared defaults and mode encoding for the windowed comparator counter.
//  Revision: 1.0
// ============================================================================
package dig_pkg;

    localparam int N_CH        = 4;
    localparam int CNT_W       = 8;
    localparam int WIN_W       = 21;
    localparam int SYNC_STAGES = 2;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dig_ch_cnt.sv
`default_nettype none
// ============================================================================
//  dig_ch_cnt
//  One comparator channel: synchronizer, edge detect, saturating accumulator
//  with sticky overflow, and the latched window result.
//  Revision: 1.0
// ============================================================================
module dig_ch_cnt #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_async,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_capture,
    output logic [CNT_W-1:0] o_t,
    output logic             o_ovf
);
    import dig_pkg::*;

    localparam logic [CNT_W-1:0] c_max = '1;
    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;
    logic [CNT_W-1:0]       r_acc;
    logic                   r_sticky;

    logic                   w_level;
    logic                   w_inc;
    logic                   w_at_max;
    logic [CNT_W-1:0]       w_acc_next;
    logic                   w_ovf_now;

    assign w_level    = r_sync[SYNC_STAGES-1];
    assign w_inc      = (i_mode == MODE_EDGE) ? (w_level & ~r_dly) : w_level;
    assign w_at_max   = (r_acc == c_max);
    assign w_acc_next = (w_inc && !w_at_max) ? (r_acc + c_one) : r_acc;
    // Overflow needs an event arriving while the accumulator is already full.
    assign w_ovf_now  = r_sticky | (w_inc & w_at_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_dly    <= 1'b0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            o_t      <= '0;
            o_ovf    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= w_level;
            if (!i_en) begin
                r_acc    <= '0;
                r_sticky <= 1'b0;
            end else if (i_capture) begin
                o_t      <= w_acc_next;
                o_ovf    <= w_ovf_now;
                r_acc    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_acc    <= w_acc_next;
                r_sticky <= w_ovf_now;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dig_win_cnt.sv
`default_nettype none
// ============================================================================
//  dig_win_cnt
//  Multi-channel windowed event counter: shared window timer and capture
//  control driving N_CH per-channel counters.
//  Revision: 1.0
// ============================================================================
module dig_win_cnt #(
    parameter int N_CH        = dig_pkg::N_CH,
    parameter int CNT_W       = dig_pkg::CNT_W,
    parameter int WIN_W       = dig_pkg::WIN_W,
    parameter int SYNC_STAGES = dig_pkg::SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [WIN_W-1:0]      win_len,
    input  logic [N_CH-1:0]       Voutc,
    output logic [N_CH*CNT_W-1:0] T,
    output logic                  t_valid,
    output logic [N_CH-1:0]       ovf
);
    import dig_pkg::*;

    localparam logic [WIN_W-1:0] c_one_win = {{(WIN_W-1){1'b0}}, 1'b1};

    logic             r_active;
    logic [WIN_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_t_valid;

    logic [WIN_W-1:0] w_win_m1;
    logic [WIN_W-1:0] w_cnt_cur;
    logic             w_mode_cur;
    logic             w_capture;

    // A zero window length behaves as a one-cycle window.
    assign w_win_m1   = (win_len == '0) ? '0 : (win_len - c_one_win);
    // The first enabled cycle after idle is itself the first window cycle.
    assign w_cnt_cur  = r_active ? r_cnt  : w_win_m1;
    assign w_mode_cur = r_active ? r_mode : mode;
    assign w_capture  = en & (w_cnt_cur == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_mode    <= MODE_LEVEL;
            r_t_valid <= 1'b0;
        end else begin
            r_t_valid <= w_capture;
            if (!en) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else if (w_capture) begin
                r_active <= 1'b1;
                r_cnt    <= w_win_m1;
                r_mode   <= mode;
            end else begin
                r_active <= 1'b1;
                r_cnt    <= w_cnt_cur - c_one_win;
                r_mode   <= w_mode_cur;
            end
        end
    end

    assign t_valid = r_t_valid;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        dig_ch_cnt #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_async   (Voutc[g]),
            .i_en      (en),
            .i_mode    (w_mode_cur),
            .i_capture (w_capture),
            .o_t       (T[g*CNT_W +: CNT_W]),
            .o_ovf     (ovf[g])
        );
    end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_dig_win_cnt.sv
`default_nettype none
// ============================================================================
//  tb_dig_win_cnt
//  Self-checking bench: vector table, directed window sequences and a
//  randomized run compared cycle by cycle against a behavioural model.
//  Revision: 1.0
// ============================================================================
module tb_dig_win_cnt;
    import dig_pkg::*;

    localparam int c_n  = 4;
    localparam int c_w  = 8;
    localparam int c_ww = 21;
    localparam int c_s  = 2;
    localparam int c_max = (1 << c_w) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              mode = 1'b0;
    logic [c_ww-1:0]   win_len = '0;
    logic [c_n-1:0]    voutc = '0;
    logic [c_n*c_w-1:0] t;
    logic              t_valid;
    logic [c_n-1:0]    ovf;

    int checks = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    dig_win_cnt #(
        .N_CH(c_n), .CNT_W(c_w), .WIN_W(c_ww), .SYNC_STAGES(c_s)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .win_len(win_len),
        .Voutc(voutc), .T(t), .t_valid(t_valid), .ovf(ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int eff(input logic [c_ww-1:0] w);
        return (w == '0) ? 1 : int'(w);
    endfunction

    // Behavioural model: input history line, event totals per window.
    logic [c_n-1:0] hist [0:c_s];
    bit             m_active;
    int             m_rem;
    logic           m_mode;
    int             m_cnt [c_n];
    logic [31:0]    exp_t;
    logic [c_n-1:0] exp_ovf;
    logic           exp_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= c_s; i++) hist[i] = '0;
            for (int k = 0; k < c_n; k++) m_cnt[k] = 0;
            m_active = 0; m_rem = 0; m_mode = 1'b0;
            exp_t = '0; exp_ovf = '0; exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (!en) begin
                m_active = 0;
                for (int k = 0; k < c_n; k++) m_cnt[k] = 0;
            end else begin
                if (!m_active) begin
                    m_active = 1;
                    m_rem = eff(win_len);
                    m_mode = mode;
                    for (int k = 0; k < c_n; k++) m_cnt[k] = 0;
                end
                for (int k = 0; k < c_n; k++) begin
                    if (m_mode == MODE_EDGE) m_cnt[k] += int'(hist[c_s-1][k] && !hist[c_s][k]);
                    else                     m_cnt[k] += int'(hist[c_s-1][k]);
                end
                m_rem--;
                if (m_rem == 0) begin
                    for (int k = 0; k < c_n; k++) begin
                        exp_t[k*c_w +: c_w] = c_w'((m_cnt[k] > c_max) ? c_max : m_cnt[k]);
                        exp_ovf[k] = (m_cnt[k] > c_max);
                        m_cnt[k] = 0;
                    end
                    exp_valid = 1'b1;
                    m_rem = eff(win_len);
                    m_mode = mode;
                end
            end
            for (int i = c_s; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = voutc;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_T", t, exp_t);
            chk("model_ovf", 32'(ovf), 32'(exp_ovf));
            chk("model_t_valid", 32'(t_valid), 32'(exp_valid));
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b1; en = 1'b0;
        @(negedge clk);
        @(negedge clk); #2 rst = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, input string nm, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk); cyc++;
            if (t_valid) return;
            if (cyc >= limit) begin
                checks++; failures++;
                $display("FAIL %s timeout after %0d cycles without t_valid", nm, cyc);
                cyc = -1;
                return;
            end
        end
    endtask

    typedef struct {
        logic [c_ww-1:0] wl;
        logic            md;
        logic [c_n-1:0]  v;
        logic [31:0]     et;
        logic [c_n-1:0]  eo;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cyc;
        int pulses;
        int v0;
        int en_low_valid;

        tbl[0] = '{21'd10,  MODE_LEVEL, 4'b1111, 32'h0A0A0A0A, 4'b0000};
        tbl[1] = '{21'd300, MODE_LEVEL, 4'b1111, 32'hFFFFFFFF, 4'b1111};
        tbl[2] = '{21'd255, MODE_LEVEL, 4'b1111, 32'hFFFFFFFF, 4'b0000};
        tbl[3] = '{21'd256, MODE_LEVEL, 4'b0011, 32'h0000FFFF, 4'b0011};
        tbl[4] = '{21'd0,   MODE_LEVEL, 4'b1010, 32'h01000100, 4'b0000};
        tbl[5] = '{21'd1,   MODE_LEVEL, 4'b0101, 32'h00010001, 4'b0000};
        tbl[6] = '{21'd10,  MODE_EDGE,  4'b1111, 32'h00000000, 4'b0000};
        tbl[7] = '{21'd7,   MODE_LEVEL, 4'b0110, 32'h00070700, 4'b0000};

        do_reset();
        chk_on = 1'b1;
        chk("reset_T", t, 32'h0);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_t_valid", 32'(t_valid), 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            @(negedge clk);
            win_len = tbl[i].wl; mode = tbl[i].md; voutc = tbl[i].v; en = 1'b1;
            for (int p = 0; p < 3; p++) wait_pulse(eff(tbl[i].wl) + 10, $sformatf("tbl%0d_wait", i), cyc);
            chk($sformatf("tbl%0d_T", i), t, tbl[i].et);
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].eo));
        end

        // Saturated window followed by quiet inputs.
        do_reset();
        @(negedge clk); win_len = 21'd300; mode = MODE_LEVEL; voutc = 4'b1111; en = 1'b1;
        for (int p = 0; p < 2; p++) wait_pulse(320, "sat_wait", cyc);
        chk("sat_T", t, 32'hFFFFFFFF);
        chk("sat_ovf", 32'(ovf), 32'hF);
        voutc = 4'b0000;
        for (int p = 0; p < 2; p++) wait_pulse(320, "quiet_wait", cyc);
        chk("quiet_T", t, 32'h0);
        chk("quiet_ovf", 32'(ovf), 32'h0);

        // Edge mode with channel 0 toggling every 4 cycles.
        do_reset();
        @(negedge clk); win_len = 21'd100; mode = MODE_EDGE; voutc = 4'b0000; en = 1'b1;
        pulses = 0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (c % 4 == 0) voutc[0] = ~voutc[0];
            if (t_valid) begin
                pulses++;
                if (pulses >= 2) begin
                    v0 = int'(t[c_w-1:0]);
                    checks++;
                    if (v0 < 12 || v0 > 13) begin
                        failures++;
                        $display("FAIL toggle_T0 actual=%0d required=12..13", v0);
                    end
                    chk("toggle_T1", 32'(t[2*c_w-1:c_w]), 32'h0);
                end
            end
        end
        chk("toggle_pulses", 32'(pulses), 32'd4);

        // Window length change takes effect at the next window.
        do_reset();
        @(negedge clk); win_len = 21'd50; mode = MODE_LEVEL; voutc = 4'b1111; en = 1'b1;
        wait_pulse(80, "len_first", cyc);
        chk("len_first_gap", 32'(cyc), 32'd50);
        for (int c = 0; c < 10; c++) @(negedge clk);
        win_len = 21'd20;
        wait_pulse(80, "len_cur", cyc);
        chk("len_cur_gap", 32'(cyc + 10), 32'd50);
        wait_pulse(80, "len_next", cyc);
        chk("len_next_gap", 32'(cyc), 32'd20);
        wait_pulse(80, "len_next2", cyc);
        chk("len_next2_gap", 32'(cyc), 32'd20);

        // Reset mid-window, then enable held low mid-window.
        do_reset();
        @(negedge clk); win_len = 21'd30; voutc = 4'b1111; en = 1'b1;
        wait_pulse(60, "rst_pre", cyc);
        for (int c = 0; c < 10; c++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_T", t, 32'h0);
        chk("rst_mid_ovf", 32'(ovf), 32'h0);
        chk("rst_mid_t_valid", 32'(t_valid), 32'h0);
        @(negedge clk);
        @(negedge clk); #2 rst = 1'b0;
        wait_pulse(60, "rst_post", cyc);
        chk("rst_post_gap", 32'(cyc), 32'd30);
        wait_pulse(60, "rst_post2", cyc);
        chk("rst_post2_T", t, 32'h1E1E1E1E);
        for (int c = 0; c < 10; c++) @(negedge clk);
        en = 1'b0;
        en_low_valid = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (t_valid) en_low_valid++;
        end
        chk("en_low_t_valid", 32'(en_low_valid), 32'h0);
        chk("en_low_T_hold", t, 32'h1E1E1E1E);
        en = 1'b1;
        wait_pulse(60, "en_post", cyc);
        chk("en_post_gap", 32'(cyc), 32'd30);
        chk("en_post_T", t, 32'h1E1E1E1E);

        // Randomized run checked against the model.
        do_reset();
        @(negedge clk); win_len = 21'd5; en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) == 0) win_len = c_ww'($urandom_range(0, 40));
            if ($urandom_range(0, 99) < 3) mode = 1'($urandom_range(0, 1));
            voutc = voutc ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk); #2 rst = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
